snes_rom_seq: RTL

- Access sequencer directly downstream of the address decoder.
- Consumes the decoded ROM address, ROM_HIT and IS_WRITABLE, plus the SNES bus strobes.
- Runs timed read/write cycles on the external SRAM0/PSRAM port, which is shared with MCU requests; SNES has priority.
- Returns read data to the SNES data bus driver and to the MCU.

---
 rtl/snes_rom_seq_if.sv | 41 ++++
 rtl/snes_rom_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/snes_rom_seq_if.sv
// snes_rom_seq_if: bus bundle between the ROM access sequencer and its surroundings.
//   master : requester side. It drives the SNES strobes, the decoder results, the SNES write
//            data, the MCU request, address and data, and the memory read data ROM_DQ_IN.
//            It observes the returned read data, MCU_RDY and the external memory controls.
//   slave  : the sequencer (snes_rom_seq).
interface snes_rom_seq_if;
  logic        SNES_RD_N;
  logic        SNES_WR_N;
  logic [23:0] SNES_ADDR_ROM;
  logic        ROM_HIT;
  logic        IS_WRITABLE;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;
  logic        MCU_RRQ;
  logic        MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT;
  logic [7:0]  MCU_DIN;
  logic        MCU_RDY;
  logic [23:0] ROM_ADDR;
  logic [7:0]  ROM_DQ_IN;
  logic [7:0]  ROM_DQ_OUT;
  logic        ROM_DQ_OE;
  logic        ROM_CE_N;
  logic        ROM_OE_N;
  logic        ROM_WE_N;

  modport master (
    output SNES_RD_N, SNES_WR_N, SNES_ADDR_ROM, ROM_HIT, IS_WRITABLE, SNES_DATA_IN,
           MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, ROM_DQ_IN,
    input  SNES_DATA_OUT, MCU_DIN, MCU_RDY, ROM_ADDR, ROM_DQ_OUT, ROM_DQ_OE,
           ROM_CE_N, ROM_OE_N, ROM_WE_N
  );

  modport slave (
    input  SNES_RD_N, SNES_WR_N, SNES_ADDR_ROM, ROM_HIT, IS_WRITABLE, SNES_DATA_IN,
           MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, ROM_DQ_IN,
    output SNES_DATA_OUT, MCU_DIN, MCU_RDY, ROM_ADDR, ROM_DQ_OUT, ROM_DQ_OE,
           ROM_CE_N, ROM_OE_N, ROM_WE_N
  );
endinterface

// File: rtl/snes_rom_seq.sv
// snes_rom_seq: access sequencer for the shared SRAM0/PSRAM port.
// It runs timed read and write cycles for SNES accesses that the address decoder marked
// as ROM hits, and for MCU requests. SNES always wins arbitration, but an access that has
// already started is never preempted. Read data goes back to the SNES bus (SNES_DATA_OUT)
// or to the MCU (MCU_DIN).
// Ports:
//   CLK, RST_N : system clock and asynchronous active-low reset
//   bus        : snes_rom_seq_if.slave. It carries the SNES strobes, address and data, the
//                decoder flags, the MCU request, address and data, and the external memory
//                address, data and control pins.
module snes_rom_seq #(
  parameter int unsigned RD_CYCLES   = 6,
  parameter int unsigned WR_CYCLES   = 6,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  snes_rom_seq_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic          serve_mcu;

  // Strobe synchronizers. The extra *_last flop holds the previous synchronized level
  // so that edges can be detected.
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
  logic                   rd_last, wr_last;

  logic snes_rd_start, snes_wr_start, snes_start;

  logic        snes_pend, snes_wr_q;
  logic [23:0] snes_addr_q;
  logic [7:0]  snes_data_q;

  logic        mcu_pend, mcu_wr_q, mcu_rdy;
  logic [23:0] mcu_addr_q;
  logic [7:0]  mcu_data_q;

  logic [23:0] rom_addr;
  logic [7:0]  rom_dq_out, snes_data_out, mcu_din;
  logic        rom_dq_oe, rom_ce_n, rom_oe_n, rom_we_n;

  logic        sel_go, sel_mcu, sel_wr;
  logic [23:0] sel_addr;
  logic [7:0]  sel_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_sync <= '1;
      wr_sync <= '1;
      rd_last <= 1'b1;
      wr_last <= 1'b1;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.SNES_RD_N};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.SNES_WR_N};
      rd_last <= rd_sync[SYNC_STAGES-1];
      wr_last <= wr_sync[SYNC_STAGES-1];
    end
  end

  assign snes_rd_start = rd_last & ~rd_sync[SYNC_STAGES-1] & bus.ROM_HIT;
  assign snes_wr_start = ~wr_last & wr_sync[SYNC_STAGES-1] & bus.ROM_HIT & bus.IS_WRITABLE;
  assign snes_start    = snes_rd_start | snes_wr_start;

  // Choose the next access as seen from IDLE. A start in this cycle uses the live
  // decoder and data inputs directly and supersedes an older pending SNES access.
  always_comb begin
    sel_go   = 1'b0;
    sel_mcu  = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (snes_start) begin
      sel_go   = 1'b1;
      sel_wr   = snes_wr_start;
      sel_addr = bus.SNES_ADDR_ROM;
      sel_data = bus.SNES_DATA_IN;
    end else if (snes_pend) begin
      sel_go   = 1'b1;
      sel_wr   = snes_wr_q;
      sel_addr = snes_addr_q;
      sel_data = snes_data_q;
    end else if (mcu_pend) begin
      sel_go   = 1'b1;
      sel_mcu  = 1'b1;
      sel_wr   = mcu_wr_q;
      sel_addr = mcu_addr_q;
      sel_data = mcu_data_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      cnt           <= '0;
      serve_mcu     <= 1'b0;
      snes_pend     <= 1'b0;
      snes_wr_q     <= 1'b0;
      snes_addr_q   <= '0;
      snes_data_q   <= '0;
      mcu_pend      <= 1'b0;
      mcu_wr_q      <= 1'b0;
      mcu_addr_q    <= '0;
      mcu_data_q    <= '0;
      mcu_rdy       <= 1'b1;
      rom_addr      <= '0;
      rom_dq_out    <= '0;
      rom_dq_oe     <= 1'b0;
      rom_ce_n      <= 1'b1;
      rom_oe_n      <= 1'b1;
      rom_we_n      <= 1'b1;
      snes_data_out <= '0;
      mcu_din       <= '0;
    end else begin
      // Outside IDLE a SNES start is parked in the one-deep slot, and the newest start wins.
      if (snes_start && state != IDLE) begin
        snes_pend   <= 1'b1;
        snes_wr_q   <= snes_wr_start;
        snes_addr_q <= bus.SNES_ADDR_ROM;
        snes_data_q <= bus.SNES_DATA_IN;
      end

      case (state)
        IDLE: begin
          if (sel_go) begin
            serve_mcu <= sel_mcu;
            rom_addr  <= sel_addr;
            rom_ce_n  <= 1'b0;
            if (!sel_mcu) snes_pend <= 1'b0;
            if (sel_wr) begin
              state      <= WR;
              rom_we_n   <= 1'b0;
              rom_dq_oe  <= 1'b1;
              rom_dq_out <= sel_data;
              cnt        <= CW'(WR_CYCLES - 1);
            end else begin
              state    <= RD;
              rom_oe_n <= 1'b0;
              cnt      <= CW'(RD_CYCLES - 1);
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            state    <= DONE;
            rom_ce_n <= 1'b1;
            rom_oe_n <= 1'b1;
            if (serve_mcu) begin
              mcu_din  <= bus.ROM_DQ_IN;
              mcu_pend <= 1'b0;
              mcu_rdy  <= 1'b1;
            end else begin
              snes_data_out <= bus.ROM_DQ_IN;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR: begin
          if (cnt == '0) begin
            // DQ_OE, DQ_OUT and ADDR stay driven through DONE for write hold time.
            state    <= DONE;
            rom_ce_n <= 1'b1;
            rom_we_n <= 1'b1;
            if (serve_mcu) begin
              mcu_pend <= 1'b0;
              mcu_rdy  <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          rom_dq_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // This comes after the FSM so that a request arriving in the completion cycle is not lost.
      if (bus.MCU_WRQ || bus.MCU_RRQ) begin
        mcu_pend   <= 1'b1;
        mcu_wr_q   <= bus.MCU_WRQ;
        mcu_addr_q <= bus.MCU_ADDR;
        mcu_data_q <= bus.MCU_DOUT;
        mcu_rdy    <= 1'b0;
      end
    end
  end

  assign bus.ROM_ADDR      = rom_addr;
  assign bus.ROM_DQ_OUT    = rom_dq_out;
  assign bus.ROM_DQ_OE     = rom_dq_oe;
  assign bus.ROM_CE_N      = rom_ce_n;
  assign bus.ROM_OE_N      = rom_oe_n;
  assign bus.ROM_WE_N      = rom_we_n;
  assign bus.SNES_DATA_OUT = snes_data_out;
  assign bus.MCU_DIN       = mcu_din;
  assign bus.MCU_RDY       = mcu_rdy;

endmodule
